cla_serial_adder: RTL and testbench



---
 rtl/cla_pkg.sv | 20 ++
 rtl/generic_cla.sv | 32 +++
 rtl/cla_serial_adder.sv | 147 ++++++++++++++
 tb/tb_cla_serial_adder.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/cla_pkg.sv
// Shared types and constants for the nibble-serial CLA adder.
// Holds the FSM encoding, slice width and index-width helper.
package cla_pkg;

    localparam int unsigned SLICE_W = 4;

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'b00;
    localparam state_t RUN  = 2'b01;
    localparam state_t DONE = 2'b10;

    // Slice-index width for a given operand width; at least one bit.
    function automatic int unsigned idx_width(input int unsigned width);
        int unsigned n;
        n = width / SLICE_W;
        idx_width = (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/generic_cla.sv
// 4-bit carry-lookahead adder slice; all carries computed in parallel
// from generate/propagate terms.
module generic_cla
    import cla_pkg::*;
(
    output logic [SLICE_W-1:0] sum,
    output logic               cout,
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               c0
);

    logic [SLICE_W-1:0] g;
    logic [SLICE_W-1:0] p;
    logic [SLICE_W:0]   c;

    assign g = a & b;
    assign p = a ^ b;

    assign c[0] = c0;
    assign c[1] = g[0] | (p[0] & c0);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & c0);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & c0);

    assign sum  = p ^ c[SLICE_W-1:0];
    assign cout = c[SLICE_W];

endmodule

// File: rtl/cla_serial_adder.sv
// Multi-cycle WIDTH-bit adder that streams operands LSB-first through one
// 4-bit CLA slice, rippling the carry through a register between cycles.
module cla_serial_adder
    import cla_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned N     = WIDTH / SLICE_W;
    localparam int unsigned IDX_W = idx_width(WIDTH);
    localparam int unsigned MSB   = WIDTH - 1;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]   a_w_q, a_w_d;
    logic [WIDTH-1:0]   b_w_q, b_w_d;
    logic [WIDTH-1:0]   sum_w_q, sum_w_d;
    logic               carry_q, carry_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;

    logic [SLICE_W-1:0] a_sl;
    logic [SLICE_W-1:0] b_sl;
    logic [SLICE_W-1:0] cla_sum;
    logic               cla_cout;

    // Slice mux: select the current nibble of each working operand.
    always_comb begin
        a_sl = '0;
        b_sl = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (idx_q == IDX_W'(i)) begin
                a_sl = a_w_q[i*SLICE_W +: SLICE_W];
                b_sl = b_w_q[i*SLICE_W +: SLICE_W];
            end
        end
    end

    generic_cla u_cla (
        .sum  (cla_sum),
        .cout (cla_cout),
        .a    (a_sl),
        .b    (b_sl),
        .c0   (carry_q)
    );

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_w_d   = a_w_q;
        b_w_d   = b_w_q;
        sum_w_d = sum_w_q;
        carry_d = carry_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        case (state_q)
            RUN: begin
                for (int unsigned i = 0; i < N; i++) begin
                    if (idx_q == IDX_W'(i)) begin
                        sum_w_d[i*SLICE_W +: SLICE_W] = cla_sum;
                    end
                end
                carry_d = cla_cout;
                if (idx_q == IDX_W'(N - 1)) begin
                    state_d = DONE;
                    idx_d   = '0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    sum_d   = sum_w_d;
                    cout_d  = cla_cout;
                    ovf_d   = (a_w_q[MSB] == b_w_q[MSB]) && (sum_w_d[MSB] != a_w_q[MSB]);
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            default: begin
                // IDLE and DONE both accept a new request.
                busy_d = 1'b0;
                if (start) begin
                    state_d = RUN;
                    idx_d   = '0;
                    a_w_d   = a;
                    b_w_d   = b;
                    carry_d = cin;
                    busy_d  = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            a_w_q   <= '0;
            b_w_q   <= '0;
            sum_w_q <= '0;
            carry_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_w_q   <= a_w_d;
            b_w_q   <= b_w_d;
            sum_w_q <= sum_w_d;
            carry_q <= carry_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_cla_serial_adder.sv
// Directed self-checking bench for cla_serial_adder at WIDTH=16.
module tb_cla_serial_adder;

    localparam int unsigned WIDTH = 16;

    logic             clk   = 1'b0;
    logic             rst   = 1'b1;
    logic             start = 1'b0;
    logic [WIDTH-1:0] a     = '0;
    logic [WIDTH-1:0] b     = '0;
    logic             cin   = 1'b0;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    int n_chk  = 0;
    int n_pass = 0;

    cla_serial_adder #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic issue(input logic [WIDTH-1:0] ai, input logic [WIDTH-1:0] bi, input logic ci);
        start = 1'b1;
        a     = ai;
        b     = bi;
        cin   = ci;
    endtask

    // Waits (bounded) for done; optionally injects a start during RUN at cycle 'inject'.
    task automatic wait_done(input int inject, output int cyc, output int busy_cnt);
        cyc      = 0;
        busy_cnt = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            if (inject != 0 && k == inject) issue(16'hFFFF, 16'hFFFF, 1'b1);
            if (inject != 0 && k == inject + 1) start = 1'b0;
            if (busy) busy_cnt++;
            if (done) begin
                cyc = k;
                break;
            end
        end
    endtask

    task automatic run_op(input string tag, input logic [WIDTH-1:0] ai, input logic [WIDTH-1:0] bi,
                          input logic ci, input logic [WIDTH-1:0] es, input logic ec,
                          input logic eo, input int inject);
        int cyc;
        int bc;
        issue(ai, bi, ci);
        wait_done(inject, cyc, bc);
        check({tag, "_latency"}, 32'(cyc), 32'd5);
        check({tag, "_busy_cycles"}, 32'(bc), 32'd4);
        check({tag, "_sum"}, 32'(sum), 32'(es));
        check({tag, "_cout"}, 32'(cout), 32'(ec));
        check({tag, "_ovf"}, 32'(ovf), 32'(eo));
    endtask

    initial begin
        int dones;

        repeat (2) @(negedge clk);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_cout", 32'(cout), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        run_op("zero", 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 0);
        @(negedge clk);
        check("zero_done_pulse", 32'(done), 32'd0);

        run_op("ripple", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 0);
        @(negedge clk);

        run_op("ovf", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 0);
        @(negedge clk);

        run_op("mixed", 16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0, 0);
        @(negedge clk);

        run_op("ignore", 16'hAAAA, 16'h5555, 1'b1, 16'h0000, 1'b1, 1'b0, 2);
        dones = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (done) dones++;
        end
        check("ignore_extra_done", 32'(dones), 32'd0);
        check("ignore_idle_busy", 32'(busy), 32'd0);

        run_op("b2b_first", 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, 0);
        run_op("b2b_second", 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0, 0);
        @(negedge clk);
        check("b2b_done_pulse", 32'(done), 32'd0);

        issue(16'h1234, 16'h1111, 1'b0);
        @(negedge clk);
        start = 1'b0;
        check("hold_sum_in_run", 32'(sum), 32'hFFFF);
        check("hold_busy_in_run", 32'(busy), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrun_rst_sum", 32'(sum), 32'd0);
        check("midrun_rst_cout", 32'(cout), 32'd0);
        check("midrun_rst_busy", 32'(busy), 32'd0);
        check("midrun_rst_done", 32'(done), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        dones = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (done) dones++;
        end
        check("midrun_rst_no_done", 32'(dones), 32'd0);

        run_op("fresh", 16'h0F0F, 16'hF0F0, 1'b0, 16'hFFFF, 1'b0, 1'b0, 0);
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_chk);
        $fatal(1);
    end

endmodule
